if_id_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
//  - Holds the PC and drives the instruction-memory address.
//  - Latches {PC+4, instruction, valid} into IF/ID.
//  - Obeys pc_write / IF_ID_write from the hazard detection unit.
//  - Redirects and squashes on a taken branch; counts stall and flush cycles for profiling.

---
 rtl/if_id_stage_pkg.sv | 37 +++
 rtl/if_id_stage_if.sv | 45 ++++
 rtl/if_id_stage_sat_counter.sv | 31 +++
 rtl/if_id_stage.sv | 73 +++++++
 tb/tb_if_id_stage.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_pkg
// Brief    : Shared constants and types for the fetch stage, hazard unit
//            and control decoder.
// Revision : 1.0
// ============================================================================
package if_id_stage_pkg;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] c_NOP_INSTR        = 32'h0000_0000;
    localparam int          c_CNT_W_DEFAULT    = 16;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : if_id_stage_pkg
`default_nettype wire

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_if
// Brief    : Hazard/branch control, instruction memory and IF/ID outputs of
//            the fetch stage.
// Revision : 1.0
// ============================================================================
interface if_id_stage_if;

    logic        pc_write;
    logic        IF_ID_write;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;

    modport master (
        output pc_write,
        output IF_ID_write,
        output flush,
        output branch_target,
        output imem_instr,
        input  imem_addr,
        input  IF_ID_pc_plus4,
        input  IF_ID_instr,
        input  IF_ID_valid
    );

    modport slave (
        input  pc_write,
        input  IF_ID_write,
        input  flush,
        input  branch_target,
        input  imem_instr,
        output imem_addr,
        output IF_ID_pc_plus4,
        output IF_ID_instr,
        output IF_ID_valid
    );

endinterface : if_id_stage_if
`default_nettype wire

// File: rtl/if_id_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : PC register, instruction fetch and IF/ID pipeline register with
//            stall/flush handling and profiling counters.
// Revision : 1.0
// ============================================================================
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR,
    parameter int          CNT_W     = c_CNT_W_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    if_id_stage_if.slave          bus,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [31:0] r_pc;
    if_id_t      r_if_id;
    logic [31:0] w_pc_plus4;
    logic        w_stall_inc;

    // Modulo-2^32 add: the top word wraps to zero silently
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_stall_inc = !bus.pc_write && !bus.flush;

    // Flush overrides both write enables so a squashed fetch is never held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc    <= RESET_PC;
            r_if_id <= '{pc_plus4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else if (bus.flush) begin
            r_pc    <= align_word(bus.branch_target);
            r_if_id <= '{pc_plus4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            if (bus.pc_write) begin
                r_pc <= w_pc_plus4;
            end
            if (bus.IF_ID_write) begin
                r_if_id <= '{pc_plus4: w_pc_plus4, instr: bus.imem_instr, valid: 1'b1};
            end
        end
    end

    assign bus.imem_addr      = r_pc;
    assign bus.IF_ID_pc_plus4 = r_if_id.pc_plus4;
    assign bus.IF_ID_instr    = r_if_id.instr;
    assign bus.IF_ID_valid    = r_if_id.valid;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_inc   (bus.flush),
        .o_count (flush_cnt)
    );

endmodule : if_id_stage
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed self-checking bench for the fetch stage / IF/ID register.
// Revision : 1.0
// ============================================================================
module tb_if_id_stage;

    localparam int c_CNT_W = 2;

    logic clk;
    logic rstn;
    logic [c_CNT_W-1:0] stall_cnt;
    logic [c_CNT_W-1:0] flush_cnt;
    int   n_checks;
    int   n_fail;

    if_id_stage_if bus ();

    if_id_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // Zero-wait instruction memory: word content tagged with its own address
    assign bus.imem_instr = bus.imem_addr | 32'hA000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt);
        bus.pc_write      = pcw;
        bus.IF_ID_write   = ifw;
        bus.flush         = fl;
        bus.branch_target = bt;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] p4,
                               input logic [31:0] ins, input logic vld,
                               input logic [31:0] sc, input logic [31:0] fc);
        check_eq({tag, ".pc"},    bus.imem_addr,      pc);
        check_eq({tag, ".p4"},    bus.IF_ID_pc_plus4, p4);
        check_eq({tag, ".instr"}, bus.IF_ID_instr,    ins);
        check_eq({tag, ".valid"}, 32'(bus.IF_ID_valid), 32'(vld));
        check_eq({tag, ".stall"}, 32'(stall_cnt),     sc);
        check_eq({tag, ".flush"}, 32'(flush_cnt),     fc);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #3;
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        #9 rstn = 1'b1;
        check_eq("fetch0.pc", bus.imem_addr, 32'h0);

        // Sequential fetch
        step();
        check_state("fetch1", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 0, 0);
        step();
        check_state("fetch2", 32'h8, 32'h8, 32'hA000_0004, 1'b1, 0, 0);

        // Two-cycle stall at PC=8
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        check_state("stall", 32'h8, 32'h8, 32'hA000_0004, 1'b1, 2, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_state("resume", 32'hC, 32'hC, 32'hA000_0008, 1'b1, 2, 0);

        // Flush overrides a stall request
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        step();
        check_state("flush", 32'h40, 32'h0, 32'h0, 1'b0, 2, 1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_state("target", 32'h44, 32'h44, 32'hA000_0040, 1'b1, 2, 1);

        // Misaligned target is forced to a word boundary
        drive(1'b1, 1'b1, 1'b1, 32'h43);
        step();
        check_state("align", 32'h40, 32'h0, 32'h0, 1'b0, 2, 2);

        // PC wraparound at the top of the address space
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        check_eq("top.pc", bus.imem_addr, 32'hFFFF_FFFC);
        check_eq("top.flush", 32'(flush_cnt), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_state("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 2, 3);

        // Flush counter holds at all-ones
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        step();
        check_eq("flsat.flush", 32'(flush_cnt), 32'd3);
        check_eq("flsat.pc", bus.imem_addr, 32'h100);

        // Asynchronous reset mid-cycle during a stall
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("prerst.stall", 32'(stall_cnt), 32'd3);
        #2 rstn = 1'b0;
        #1;
        check_state("asyncrst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
        #1 rstn = 1'b1;

        // Stall counter saturates after five stall cycles
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check_state("stsat", 32'h0, 32'h0, 32'h0, 1'b0, 3, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_state("postrst", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_id_stage
`default_nettype wire
